// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared constants and types for the RV32I memory stage
//
// Purpose: funct3 size/sign codes, write-back select codes, Control_Signal
// field positions and the access FSM state type used by mem_stage and
// load_store_align.
package mem_stage_pkg;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Write-back select codes carried in Control_Signal[1:0]
  localparam logic [1:0] WB_FU  = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  // Control_Signal field positions
  localparam int CTRL_RD_HI    = 7;
  localparam int CTRL_RD_LO    = 3;
  localparam int CTRL_REG_WE   = 2;
  localparam int CTRL_WBSEL_HI = 1;
  localparam int CTRL_WBSEL_LO = 0;

  // Access sizes as encoded in funct3[1:0]
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/load_store_align.sv
// rtl/load_store_align.sv - store lane generation, load extraction and fault detection
//
// Purpose: purely combinational helper for mem_stage.
// Ports:
//   valid, mem_read, mem_write  - instruction qualifiers
//   funct3                      - RV32I size/sign code
//   off                         - byte offset within the word (FU_i[1:0])
//   store_data                  - rs2 value for stores
//   rdata                       - word returned by data memory
//   be, wdata                   - store byte enables / lane-replicated data
//   load_data                   - aligned, extended load value (0 unless a good load)
//   fault                       - misaligned or illegal-funct3 memory op
module load_store_align
  import mem_stage_pkg::*;
#(
  parameter int size = 32
) (
  input  logic            valid,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [size-1:0] store_data,
  input  logic [size-1:0] rdata,
  output logic [3:0]      be,
  output logic [size-1:0] wdata,
  output logic [size-1:0] load_data,
  output logic            fault
);

  logic       legal_load;
  logic       legal_store;
  logic       misaligned;
  logic       illegal;
  logic [7:0] sel_byte;
  logic [15:0] sel_half;
  logic [size-1:0] load_val;

  always_comb begin
    legal_load  = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                  (funct3 == F3_LBU) || (funct3 == F3_LHU);
    legal_store = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    misaligned  = ((funct3[1:0] == SZ_HALF) && off[0]) ||
                  ((funct3[1:0] == SZ_WORD) && (off != 2'b00));
    illegal     = (mem_read && !legal_load) || (mem_write && !legal_store);
    fault       = valid && (mem_read || mem_write) && (misaligned || illegal);
  end

  // Store lanes: data is replicated so the addressed lane always carries it,
  // whatever the offset; the byte enables pick the lane(s) actually written.
  always_comb begin
    be    = 4'b0000;
    wdata = '0;
    case (funct3[1:0])
      SZ_BYTE: begin
        be    = 4'b0001 << off;
        wdata = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      SZ_WORD: begin
        be    = 4'b1111;
        wdata = store_data;
      end
      default: begin
        be    = 4'b0000;
        wdata = '0;
      end
    endcase
  end

  // Load extraction: pick the addressed byte/half, then extend.
  always_comb begin
    sel_byte = rdata[{off, 3'b000} +: 8];
    sel_half = off[1] ? rdata[31:16] : rdata[15:0];
    load_val = '0;
    case (funct3)
      F3_LB:   load_val = {{(size-8){sel_byte[7]}}, sel_byte};
      F3_LBU:  load_val = {{(size-8){1'b0}}, sel_byte};
      F3_LH:   load_val = {{(size-16){sel_half[15]}}, sel_half};
      F3_LHU:  load_val = {{(size-16){1'b0}}, sel_half};
      F3_LW:   load_val = rdata;
      default: load_val = '0;
    endcase
    load_data = (valid && mem_read && !fault) ? load_val : '0;
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32I memory-access stage with dmem handshake and MEM/WB register
//
// Purpose: issues loads/stores over a req/ack interface, stalls the pipe
// while an access is outstanding and registers the MEM/WB slot.
// Ports:
//   clk, rst_n                       - clock, synchronous active-low reset
//   valid_i, FU_i, store_data_i,
//   PCplus_i, mem_read_i, mem_write_i,
//   funct3_i, Control_Signal_i       - EX/MEM slot
//   dmem_req_o, dmem_we_o, dmem_addr_o,
//   dmem_wdata_o, dmem_be_o          - data memory request
//   dmem_ack_i, dmem_rdata_i         - data memory completion
//   stall_o                          - freeze upstream stages
//   valid_o, FU_o, MEM_result_o,
//   PCplus_o, Control_Signal_o,
//   misalign_o                       - MEM/WB slot
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic [size-1:0] FU_i,
  input  logic [size-1:0] store_data_i,
  input  logic [size-1:0] PCplus_i,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic [2:0]      funct3_i,
  input  logic [7:0]      Control_Signal_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [size-1:0] dmem_addr_o,
  output logic [size-1:0] dmem_wdata_o,
  output logic [3:0]      dmem_be_o,
  input  logic            dmem_ack_i,
  input  logic [size-1:0] dmem_rdata_i,
  output logic            stall_o,
  output logic            valid_o,
  output logic [size-1:0] FU_o,
  output logic [size-1:0] MEM_result_o,
  output logic [size-1:0] PCplus_o,
  output logic [7:0]      Control_Signal_o,
  output logic            misalign_o
);

  state_t          state;
  state_t          state_next;
  logic            fault;
  logic            acc;
  logic            req;
  logic [3:0]      lane_be;
  logic [size-1:0] lane_wdata;
  logic [size-1:0] load_data;
  logic [7:0]      ctrl_next;

  load_store_align #(.size(size)) u_align (
    .valid      (valid_i),
    .mem_read   (mem_read_i),
    .mem_write  (mem_write_i),
    .funct3     (funct3_i),
    .off        (FU_i[1:0]),
    .store_data (store_data_i),
    .rdata      (dmem_rdata_i),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .load_data  (load_data),
    .fault      (fault)
  );

  // rst_n gates acc so a held instruction cannot re-issue while reset is low.
  assign acc = rst_n && valid_i && (mem_read_i || mem_write_i) && !fault;

  always_comb begin
    state_next = state;
    req        = 1'b0;
    case (state)
      ST_IDLE: begin
        req = acc;
        if (acc && !dmem_ack_i) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // Upstream is frozen by stall_o, so address/data/BE stay stable.
        req = 1'b1;
        if (dmem_ack_i) state_next = ST_IDLE;
      end
      default: begin
        req        = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  assign dmem_req_o   = req;
  assign dmem_we_o    = req && mem_write_i;
  assign dmem_addr_o  = {FU_i[size-1:2], 2'b00};
  assign dmem_wdata_o = lane_wdata;
  assign dmem_be_o    = (req && mem_write_i) ? lane_be :
                        (req ? 4'b0000 : 4'b0000);
  assign stall_o      = req && !dmem_ack_i;

  // Register write is suppressed for bubbles and faulting instructions.
  always_comb begin
    ctrl_next               = Control_Signal_i;
    ctrl_next[CTRL_REG_WE]  = Control_Signal_i[CTRL_REG_WE] && valid_i && !fault;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      valid_o          <= 1'b0;
      FU_o             <= '0;
      MEM_result_o     <= '0;
      PCplus_o         <= '0;
      Control_Signal_o <= 8'h00;
      misalign_o       <= 1'b0;
    end else begin
      state <= state_next;
      if (stall_o) begin
        valid_o          <= 1'b0;
        Control_Signal_o <= 8'h00;
        misalign_o       <= 1'b0;
      end else begin
        valid_o          <= valid_i;
        FU_o             <= FU_i;
        MEM_result_o     <= load_data;
        PCplus_o         <= PCplus_i;
        Control_Signal_o <= ctrl_next;
        misalign_o       <= fault;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic [31:0] FU_i;
  logic [31:0] store_data_i;
  logic [31:0] PCplus_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [2:0]  funct3_i;
  logic [7:0]  Control_Signal_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_o;
  logic        valid_o;
  logic [31:0] FU_o;
  logic [31:0] MEM_result_o;
  logic [31:0] PCplus_o;
  logic [7:0]  Control_Signal_o;
  logic        misalign_o;

  always #5 clk = ~clk;

  mem_stage #(.size(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .FU_i(FU_i),
    .store_data_i(store_data_i), .PCplus_i(PCplus_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .funct3_i(funct3_i),
    .Control_Signal_i(Control_Signal_i), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o),
    .valid_o(valid_o), .FU_o(FU_o), .MEM_result_o(MEM_result_o),
    .PCplus_o(PCplus_o), .Control_Signal_o(Control_Signal_o),
    .misalign_o(misalign_o)
  );

  typedef struct {
    logic        v;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] fu;
    logic [31:0] sd;
    logic [31:0] pc;
    logic [7:0]  ctrl;
  } ins_t;

  int checks = 0;
  int errors = 0;
  int stall_cnt;
  int bubble_cnt;
  int req_cnt;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata;
  logic [31:0] obs_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int m_size(input logic [2:0] f3);
    case (f3[1:0])
      2'd0: return 1;
      2'd1: return 2;
      2'd2: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_fault(input ins_t i);
    bit legal;
    if (!(i.v && (i.rd || i.wr))) return 0;
    legal = 1;
    if (i.rd && !(i.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) legal = 0;
    if (i.wr && !(i.f3 inside {3'd0, 3'd1, 3'd2})) legal = 0;
    if (!legal) return 1;
    return (i.fu % m_size(i.f3)) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input int off, input logic [31:0] rdata);
    logic [31:0] w;
    bit uns;
    w   = rdata >> (8 * off);
    uns = (f3 == 3'd4) || (f3 == 3'd5);
    case (m_size(f3))
      1: return uns ? {24'b0, w[7:0]} : {{24{w[7]}}, w[7:0]};
      2: return uns ? {16'b0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: return rdata;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input int off);
    int m;
    m = (1 << m_size(f3)) - 1;
    return 4'(m << off);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] w;
    int sz;
    sz = m_size(f3);
    w  = 0;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = sd[8*(k % sz) +: 8];
    return w;
  endfunction

  task automatic drive(input ins_t i);
    valid_i          = i.v;
    mem_read_i       = i.rd;
    mem_write_i      = i.wr;
    funct3_i         = i.f3;
    FU_i             = i.fu;
    store_data_i     = i.sd;
    PCplus_i         = i.pc;
    Control_Signal_i = i.ctrl;
  endtask

  // Entered at posedge+1; returns at posedge+1 after the instruction retires
  // into MEM/WB. Checks every cycle against the model.
  task automatic run_instr(input ins_t i, input int lat, input logic [31:0] rdata);
    bit f, acc;
    int n;
    logic [7:0] ectrl;
    f   = m_fault(i);
    acc = i.v && (i.rd || i.wr) && !f;
    n   = acc ? lat : 0;
    stall_cnt = 0; bubble_cnt = 0; req_cnt = 0;
    drive(i);
    dmem_rdata_i = rdata;
    for (int c = 0; c <= n; c++) begin
      dmem_ack_i = acc ? (c == lat) : 1'($urandom_range(0, 1));
      #1;
      chk("req", dmem_req_o, acc);
      chk("stall", stall_o, acc && (c < lat));
      if (stall_o) stall_cnt++;
      if (dmem_req_o) req_cnt++;
      if (acc) begin
        chk("addr", dmem_addr_o, {i.fu[31:2], 2'b00});
        chk("we", dmem_we_o, i.wr);
        chk("be", dmem_be_o, i.wr ? m_be(i.f3, int'(i.fu[1:0])) : 4'b0000);
        if (i.wr) chk("wdata", dmem_wdata_o, m_wdata(i.f3, i.sd));
      end else begin
        chk("be_idle", dmem_be_o, 4'b0000);
      end
      obs_be = dmem_be_o; obs_wdata = dmem_wdata_o; obs_addr = dmem_addr_o;
      @(posedge clk);
      #1;
      if (c < n) begin
        chk("bubble_valid", valid_o, 1'b0);
        chk("bubble_ctrl", Control_Signal_o, 8'h00);
        chk("bubble_mis", misalign_o, 1'b0);
        bubble_cnt++;
      end
    end
    dmem_ack_i = 1'b0;
    ectrl = i.ctrl;
    if (!i.v || f) ectrl[2] = 1'b0;
    chk("valid_o", valid_o, i.v);
    chk("FU_o", FU_o, i.fu);
    chk("PCplus_o", PCplus_o, i.pc);
    chk("ctrl_o", Control_Signal_o, ectrl);
    chk("misalign_o", misalign_o, f);
    chk("mem_result", MEM_result_o, (acc && i.rd) ? m_load(i.f3, int'(i.fu[1:0]), rdata) : 32'h0);
  endtask

  function automatic ins_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] fu, input logic [31:0] sd, input logic [7:0] ctrl);
    ins_t i;
    i.v = 1'b1; i.rd = rd; i.wr = wr; i.f3 = f3; i.fu = fu; i.sd = sd;
    i.pc = 32'h0000_1004; i.ctrl = ctrl;
    return i;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t ins;
    rst_n = 1'b0;
    valid_i = 0; FU_i = 0; store_data_i = 0; PCplus_i = 0; mem_read_i = 0;
    mem_write_i = 0; funct3_i = 0; Control_Signal_i = 0; dmem_ack_i = 0; dmem_rdata_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_ctrl", Control_Signal_o, 8'h00);
    chk("rst_fu", FU_o, 32'h0);
    chk("rst_mem", MEM_result_o, 32'h0);
    chk("rst_pc", PCplus_o, 32'h0);
    chk("rst_mis", misalign_o, 1'b0);
    chk("rst_req", dmem_req_o, 1'b0);
    rst_n = 1'b1;

    // ALU op passes through
    ins = mk(0, 0, 3'd0, 32'h1234, 32'h0, 8'h0C);
    run_instr(ins, 0, 32'h0);
    chk("alu_fu", FU_o, 32'h0000_1234);
    chk("alu_ctrl", Control_Signal_o, 8'h0C);
    chk("alu_valid", valid_o, 1'b1);
    chk("alu_noreq", req_cnt, 0);

    // LB / LBU at 0x103, zero-wait
    ins = mk(1, 0, 3'b000, 32'h103, 32'h0, 8'h0D);
    run_instr(ins, 0, 32'h80FF_FF00);
    chk("lb_val", MEM_result_o, 32'hFFFF_FF80);
    chk("lb_nostall", stall_cnt, 0);
    ins = mk(1, 0, 3'b100, 32'h103, 32'h0, 8'h0D);
    run_instr(ins, 0, 32'h80FF_FF00);
    chk("lbu_val", MEM_result_o, 32'h0000_0080);

    // SH at 0x102
    ins = mk(0, 1, 3'b001, 32'h102, 32'h0000_ABCD, 8'h00);
    run_instr(ins, 1, 32'h0);
    chk("sh_be", obs_be, 4'b1100);
    chk("sh_wdata", obs_wdata, 32'hABCD_ABCD);
    chk("sh_addr", obs_addr, 32'h100);

    // LW at 0x200 with ack delayed 3 cycles
    ins = mk(1, 0, 3'b010, 32'h200, 32'h0, 8'h0D);
    run_instr(ins, 3, 32'hDEAD_BEEF);
    chk("lw_stalls", stall_cnt, 3);
    chk("lw_bubbles", bubble_cnt, 3);
    chk("lw_val", MEM_result_o, 32'hDEAD_BEEF);

    // Misaligned LW
    ins = mk(1, 0, 3'b010, 32'h202, 32'h0, 8'h0D);
    run_instr(ins, 0, 32'h1111_2222);
    chk("mis_flag", misalign_o, 1'b1);
    chk("mis_we", Control_Signal_o[2], 1'b0);
    chk("mis_valid", valid_o, 1'b1);
    chk("mis_noreq", req_cnt, 0);

    // Reset while waiting
    ins = mk(1, 0, 3'b010, 32'h200, 32'h0, 8'h0D);
    drive(ins);
    dmem_ack_i = 1'b0;
    @(posedge clk);
    #1;
    chk("rw_stall", stall_o, 1'b1);
    rst_n = 1'b0;
    ins = '{default: '0};
    drive(ins);
    @(posedge clk);
    #1;
    chk("rw_req", dmem_req_o, 1'b0);
    chk("rw_valid", valid_o, 1'b0);
    chk("rw_ctrl", Control_Signal_o, 8'h00);
    chk("rw_fu", FU_o, 32'h0);
    chk("rw_mem", MEM_result_o, 32'h0);
    chk("rw_mis", misalign_o, 1'b0);
    rst_n = 1'b1;
    dmem_ack_i = 1'b1;
    dmem_rdata_i = 32'hCAFE_F00D;
    #1;
    chk("late_ack_req", dmem_req_o, 1'b0);
    chk("late_ack_stall", stall_o, 1'b0);
    @(posedge clk);
    #1;
    chk("late_ack_valid", valid_o, 1'b0);
    chk("late_ack_mem", MEM_result_o, 32'h0);
    dmem_ack_i = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int kind;
      kind   = $urandom_range(0, 2);
      ins.v  = ($urandom_range(0, 9) != 0);
      ins.rd = (kind == 1);
      ins.wr = (kind == 2);
      ins.f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      if (ins.rd && $urandom_range(0, 3) == 0) ins.f3 = 3'($urandom_range(4, 5));
      ins.fu   = $urandom;
      if ($urandom_range(0, 1) == 1) ins.fu[1:0] = 2'b00;
      ins.sd   = $urandom;
      ins.pc   = $urandom;
      ins.ctrl = 8'($urandom);
      run_instr(ins, $urandom_range(0, 3), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RV32I pipeline, between EX/MEM and WB.
- Issues loads and stores to data memory over a req/ack handshake.
- Aligns and extends load data, and generates store byte enables.
- Stalls the pipe while an access is outstanding, and owns the MEM/WB pipeline register that feeds the write-back mux.

Parameters:
- size, 32, datapath/address width (XLEN).

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous reset, active low
- valid_i  in  1  EX/MEM slot holds a real instruction
- FU_i  in  size  ALU result; the byte address for memory ops
- store_data_i  in  size  rs2 value for stores
- PCplus_i  in  size  PC+4
- mem_read_i  in  1  instruction is a load
- mem_write_i  in  1  instruction is a store
- funct3_i  in  3  RV32I size/sign code
- Control_Signal_i  in  8  [7:3] rd, [2] reg write enable, [1:0] WB select (00 FU, 01 MEM, 10 PC+4)
- dmem_req_o  out  1  access request
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  size  word-aligned address, FU_i with [1:0] forced to 0
- dmem_wdata_o  out  size  lane-replicated store data
- dmem_be_o  out  4  byte enables
- dmem_ack_i  in  1  access complete; read data valid this cycle
- dmem_rdata_i  in  size  read word
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- valid_o  out  1  MEM/WB slot valid
- FU_o  out  size  registered FU_i
- MEM_result_o  out  size  registered aligned load data
- PCplus_o  out  size  registered PC+4
- Control_Signal_o  out  8  registered control; bit 2 is cleared for bubbles and faults
- misalign_o  out  1  registered fault flag for the instruction in MEM/WB

Behaviour:
- Access condition: acc = valid_i & (mem_read_i | mem_write_i) & ~fault.
- fault = valid_i & (mem_read_i | mem_write_i) & (misaligned | illegal funct3).
  - Misaligned: halfword with FU_i[0]=1, or word with FU_i[1:0]≠0.
  - Legal load funct3: 000, 001, 010, 100, 101. Legal store funct3: 000, 001, 010.
- FSM states:
  - IDLE:
    - dmem_req_o = acc, driven combinationally.
    - acc & ~dmem_ack_i → WAIT.
    - acc & dmem_ack_i → stay in IDLE, zero-wait completion.
  - WAIT:
    - dmem_req_o = 1, and address, data, BE and we are held stable.
    - dmem_ack_i → IDLE.
- stall_o = dmem_req_o & ~dmem_ack_i, combinational. Upstream holds its inputs stable while stall_o is high.
- MEM/WB register, on each rising edge:
  - rst_n=0: all outputs 0 (valid_o, misalign_o, Control_Signal_o, FU_o, MEM_result_o, PCplus_o), state → IDLE.
  - stall_o=1: insert a bubble. valid_o=0, Control_Signal_o=0, misalign_o=0, data fields don't-care (hold).
  - Otherwise: capture all inputs, with valid_o=valid_i.
    - If fault: Control_Signal_o[2]=0 and misalign_o=1.
    - Else if valid_i=0: Control_Signal_o[2]=0.
- Load alignment on dmem_rdata_i, with off=FU_i[1:0]:
  - LB / LBU: byte at off, sign- or zero-extended.
  - LH / LHU: half selected by off[1], sign- or zero-extended.
  - LW: whole word.
  - MEM_result_o = 0 for non-loads.
- Store lane generation:
  - SB: be = 0001<<off, wdata = byte replicated ×4.
  - SH: be = 0011 (off=0) or 1100 (off=2), wdata = half replicated ×2.
  - SW: be = 1111.
  - dmem_be_o = 0 when no request is active.
- Faulting instructions never assert dmem_req_o.
- Reset during WAIT: request drops in the next cycle, and a late dmem_ack_i is ignored in IDLE while acc=0.
- dmem_ack_i without a request is ignored.
- Non-memory instructions pass through with one-cycle latency and no stall.

Decomposition:
- Shared package holds:
  - funct3 constants (LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010).
  - WB select codes (FU=00, MEM=01, PC=10).
  - Control_Signal field indices.
- One sub-module, load_store_align: combinational BE/wdata generation, load extraction/extension, and fault detection. The FSM and MEM/WB register live in mem_stage.

Test Plan:
- ALU op, FU_i=0x1234, ctrl=0x0C, valid_i=1 → next edge FU_o=0x1234, Control_Signal_o=0x0C, valid_o=1, no dmem_req_o.
- LB at 0x103, rdata=0x80FF_FF00, ack same cycle → stall_o=0, MEM_result_o=0xFFFF_FF80. LBU with the same stimulus → 0x0000_0080.
- SH at 0x102, store_data=0x0000_ABCD → dmem_be_o=1100, dmem_wdata_o=0xABCD_ABCD, dmem_addr_o=0x100.
- LW at 0x200 with ack delayed 3 cycles → stall_o high for 3 cycles, 3 bubbles in MEM/WB (valid_o=0, ctrl=0), then MEM_result_o=rdata.
- LW at 0x202 → no request, misalign_o=1, Control_Signal_o[2]=0, valid_o=1.
- rst_n=0 during WAIT → next cycle dmem_req_o=0, all outputs 0, state IDLE; an ack arriving afterwards causes no capture.
